// File: rtl/port_uart_pkg.sv
// Shared encodings and helpers for the port_out-driven UART transmitter.
package port_uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Bit positions inside the status word returned to the CPU
    localparam int unsigned STAT_FULL  = 0;
    localparam int unsigned STAT_BUSY  = 1;
    localparam int unsigned STAT_EMPTY = 2;
    localparam int unsigned STAT_OVF   = 3;
    localparam int unsigned STAT_ACK   = 8;

    // Request toggle position inside port_out; [7:0] carries the byte
    localparam int unsigned PO_REQ = 8;
    localparam int unsigned BYTE_W = 8;

    // Clocks per bit, truncated
    function automatic int unsigned calc_div(input int unsigned clk_hz, input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with extra pointer MSB for full/empty detection.
// Read data is presented combinationally from the head entry.
module sync_fifo #(
    parameter int unsigned WIDTH      = 8,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned PTR_W = DEPTH_LOG2 + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push_c;
    logic             do_pop_c;

    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                       (wr_ptr_q[PTR_W-2:0] == rd_ptr_q[PTR_W-2:0]);
    assign do_push_c = push && !full;
    assign do_pop_c  = pop && !empty;
    assign dout      = mem_q[rd_ptr_q[PTR_W-2:0]];

    // Pointer advance; push and pop in the same cycle both take effect
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push_c) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop_c)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    // Pointer registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array, contents are don't-care until written
    always_ff @(posedge clk) begin
        if (do_push_c) mem_q[wr_ptr_q[PTR_W-2:0]] <= din;
    end

endmodule

// File: rtl/port_uart_tx.sv
// Console output stage: toggle-handshaked byte writes from the CPU port_out
// are queued and sent 8N1 on txd; status/ack word feeds back to port_in.
module port_uart_tx
    import port_uart_pkg::*;
#(
    parameter int unsigned WIDTH_REG       = 32,
    parameter int unsigned CLK_HZ          = 50000000,
    parameter int unsigned BAUD            = 115200,
    parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [WIDTH_REG-1:0] port_out,
    output logic [WIDTH_REG-1:0] status,
    output logic                 txd
);

    // WIDTH_REG must be >= 10 and DIV >= 2 for the framing below to hold
    localparam int unsigned DIV   = calc_div(CLK_HZ, BAUD);
    localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic              req_prev_q;
    logic              ack_q;
    logic              ovf_q;
    logic              new_req_c;
    logic              pop_c;
    logic [BYTE_W-1:0] fifo_dout;
    logic              fifo_full;
    logic              fifo_empty;

    tx_state_e         state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        bit_q, bit_d;
    logic [BYTE_W-1:0] shift_q, shift_d;
    logic              txd_q, txd_d;
    logic              bit_end_c;

    // Upper port_out bits carry no meaning here
    logic unused_port_bits;
    assign unused_port_bits = ^port_out[WIDTH_REG-1:PO_REQ+1];

    // port_out is already in the clk domain, so a plain edge compare suffices
    assign new_req_c = port_out[PO_REQ] ^ req_prev_q;
    assign bit_end_c = (cnt_q == CNT_LAST);

    sync_fifo #(
        .WIDTH      (BYTE_W),
        .DEPTH_LOG2 (FIFO_DEPTH_LOG2)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (new_req_c),
        .pop     (pop_c),
        .din     (port_out[BYTE_W-1:0]),
        .dout    (fifo_dout),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Request edge tracking; ack always follows so software never stalls
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_prev_q <= 1'b0;
            ack_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            req_prev_q <= port_out[PO_REQ];
            if (new_req_c) begin
                ack_q <= port_out[PO_REQ];
                if (fifo_full) ovf_q <= 1'b1;
            end
        end
    end

    // Frame sequencer; txd_d reflects the current state so txd lags it by one cycle
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        txd_d   = 1'b1;
        pop_c   = 1'b0;
        if (state_q != ST_IDLE) begin
            cnt_d = bit_end_c ? '0 : cnt_q + CNT_W'(1);
        end
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop_c   = 1'b1;
                    shift_d = fifo_dout;
                    cnt_d   = '0;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                txd_d = 1'b0;
                if (bit_end_c) begin
                    bit_d   = 3'd0;
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                txd_d = shift_q[0];
                if (bit_end_c) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == 3'd7) state_d = ST_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end
            end
            ST_STOP: begin
                if (bit_end_c) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Sequencer registers; async reset forces the line idle immediately
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            shift_q <= '0;
            txd_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            txd_q   <= txd_d;
        end
    end

    assign txd = txd_q;

    // Status word assembly from registered state
    always_comb begin
        status             = '0;
        status[STAT_FULL]  = fifo_full;
        status[STAT_BUSY]  = (state_q != ST_IDLE);
        status[STAT_EMPTY] = fifo_empty;
        status[STAT_OVF]   = ovf_q;
        status[STAT_ACK]   = ack_q;
    end

endmodule

// File: doc/port_uart_tx.md
Name: port_uart_tx

Overview:
- Serial console output stage sitting directly downstream of sc1_cpu port_out on DE0-CV.
- CPU writes a byte plus a toggle request bit to port_out.
- Block queues the byte in a small FIFO and transmits it 8N1 on a UART TX pin.
- Status and acknowledge are returned on a word meant to drive sc1_cpu port_in, so software can poll for flow control.

Parameters:
- WIDTH_REG, 32, width of port_out/status words; must be >= 10.
- CLK_HZ, 50000000, clk frequency in Hz.
- BAUD, 115200, line rate. DIV = CLK_HZ/BAUD, truncated integer (434 at defaults); DIV must be >= 2.
- FIFO_DEPTH_LOG2, 2, FIFO holds 2**FIFO_DEPTH_LOG2 bytes.

Ports:
- clk  input  1  system clock (CLOCK_50 at top)
- reset_n  input  1  asynchronous, active-low reset
- port_out  input  WIDTH_REG  from sc1_cpu. [7:0] data byte; [8] request toggle; other bits ignored.
- status  output  WIDTH_REG  to sc1_cpu port_in. [0] fifo_full; [1] tx_busy; [2] fifo_empty; [3] overflow (sticky); [8] ack toggle; all other bits 0.
- txd  output  1  UART serial out; idle high.

Behaviour:
- Reset values (async assert, sync release in clk domain):
  - txd=1, status=0 except fifo_empty=1.
  - req_prev=0, ack=0, overflow=0, FIFO pointers 0, FSM=IDLE, baud counter 0, bit index 0.
- Request detect:
  - Each edge, compare port_out[8] against req_prev. A mismatch at edge E is a new request; req_prev<=port_out[8].
  - port_out is already registered in the clk domain, so no synchroniser is used.
- Enqueue at edge E:
  - If not full: write port_out[7:0] into the FIFO.
  - If full: drop the byte and set overflow<=1. overflow clears only on reset.
  - In both cases ack<=port_out[8]. ack therefore always follows the request one cycle later, so software never deadlocks.
- Software protocol: poll until status[0]==0, write data with inverted toggle, then wait for status[8]==toggle.
- Simultaneous push and pop: both proceed. Count is unchanged; full/empty flags are correct in the same cycle.
- Pointers are FIFO_DEPTH_LOG2+1 bits wide; full and empty are derived from the MSB compare, and wrap-around is natural binary.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: txd=1. If FIFO is non-empty: pop into shift register, clear baud counter, go to START.
  - START: txd=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: txd=shift[0] for DIV cycles per bit, LSB first. Shift right after each bit. After bit 7, go to STOP.
  - STOP: txd=1 for DIV cycles, then go to IDLE.
- Baud counter counts 0..DIV-1; the bit period ends when the counter equals DIV-1, and the counter reloads to 0.
- Latency and framing:
  - Request sampled at E; FIFO non-empty at E+1; pop at E+1; txd low from the E+2 edge.
  - Frame length is 10*DIV cycles.
  - One IDLE cycle separates back-to-back frames.
- tx_busy=1 whenever FSM!=IDLE.
- A request arriving mid-frame only enqueues; the frame in flight is never disturbed.
- Reset mid-frame: txd returns to 1 immediately (async), the FIFO is emptied, and the partial frame is abandoned.
- txd is a registered output and is glitch-free.

Decomposition:
- Shared package port_uart_pkg:
  - FSM state encoding (IDLE=0, START=1, DATA=2, STOP=3).
  - Status bit index constants (STAT_FULL=0, STAT_BUSY=1, STAT_EMPTY=2, STAT_OVF=3, STAT_ACK=8).
  - Port bit constants (PO_REQ=8).
  - DIV computation function.
- One sub-module, sync_fifo:
  - Parameters: width 8, depth log2.
  - Ports: push, pop, din, dout, full, empty.
  - Single-clock; same async active-low reset.
- Top-level DE0-CV wiring change: status to port_in, txd to a GPIO pin.

Test Plan (CLK_HZ=1000, BAUD=100, so DIV=10; FIFO_DEPTH_LOG2=2):
- Reset check: hold reset_n=0 with arbitrary port_out -> txd=1, status=0x00000004. Release -> values hold until a toggle is seen.
- Single byte: port_out=0x155 (byte 0x55, toggle 1) at edge E -> status[8]=1 at E+1. txd low from E+2 for 10 cycles, then 1,0,1,0,1,0,1,0 each for 10 cycles, then high for 10 cycles. tx_busy=1 for 100 cycles.
- Burst: 5 toggled writes of 0x01..0x05, one per cycle, while idle -> first byte popped. FIFO reaches 4 entries with status[0]=1 and no overflow. Line output is 0x01..0x05 in order with one idle cycle between frames.
- Overflow: fill FIFO while a frame is in flight, then issue one more toggle with byte 0xAA -> byte dropped, status[3]=1, status[8] still tracks the toggle. 0xAA never appears on txd; overflow stays set until reset.
- Push and pop same cycle: FIFO holds 1 entry with FSM in IDLE; toggle a new byte on the pop cycle -> count stays 1, neither empty nor full flag glitches, and both bytes are transmitted in order.
- Reset mid-frame: assert reset_n=0 during DATA bit 3 -> txd=1 within the same cycle (async). After release: FIFO empty, FSM IDLE, no residual frame emitted.
